// File: rtl/agu_if.sv
// Request/response bundle for the address generation unit.
// The slave modport is the AGU side; the master modport is the requester/consumer side.
interface agu_if #(
  parameter int ADDR_W    = 32,
  parameter int OFF_W     = 26,
  parameter int MAX_BEATS = 8,
  parameter int BEAT_W    = $clog2(MAX_BEATS)
);
  logic              i_valid;
  logic              o_ready;
  logic [2:0]        i_opcode;
  logic [ADDR_W-1:0] i_addr;
  logic [OFF_W-1:0]  i_offset;
  logic [1:0]        i_size;
  logic [BEAT_W-1:0] i_beats;
  logic              o_valid;
  logic              i_ready;
  logic [ADDR_W-1:0] o_eff_addr;
  logic [1:0]        o_addr_exception;
  logic [BEAT_W-1:0] o_beat_idx;
  logic              o_last;

  modport slave (
    input  i_valid, i_opcode, i_addr, i_offset, i_size, i_beats, i_ready,
    output o_ready, o_valid, o_eff_addr, o_addr_exception, o_beat_idx, o_last
  );

  modport master (
    output i_valid, i_opcode, i_addr, i_offset, i_size, i_beats, i_ready,
    input  o_ready, o_valid, o_eff_addr, o_addr_exception, o_beat_idx, o_last
  );
endinterface

// File: rtl/agu_pipe.sv
// Registered address generation unit: register, base+offset, branch, jump and burst modes,
// with alignment/illegal flags and a valid/ready output stage that holds under backpressure.
module agu_pipe #(
  parameter int ADDR_W    = 32,
  parameter int IMM_W     = 16,
  parameter int OFF_W     = 26,
  parameter int MAX_BEATS = 8,
  parameter int BEAT_W    = $clog2(MAX_BEATS)
) (
  input logic  i_clk,
  input logic  i_rst_n,
  agu_if.slave bus
);

  localparam logic [2:0] OP_REG    = 3'b000;
  localparam logic [2:0] OP_BOFF   = 3'b001;
  localparam logic [2:0] OP_BRANCH = 3'b010;
  localparam logic [2:0] OP_JUMP   = 3'b011;
  localparam logic [2:0] OP_BURST  = 3'b100;

  typedef enum logic {S_IDLE, S_OUT} state_t;

  state_t state_q, state_d;

  logic vld_p1, rdy, load, step;

  logic signed [ADDR_W-1:0] sext_p0;
  logic [ADDR_W-1:0]        addr_p0;
  logic [1:0]               exc_p0;
  logic                     chk_p0, bad_p0, last_p0;

  logic [ADDR_W-1:0] eff_addr_p1, stride_p1, next_addr_p1;
  logic [1:0]        exc_p1, size_p1;
  logic [BEAT_W-1:0] beat_p1, lim_p1, next_beat_p1;
  logic              last_p1;

  // {illegal, misaligned}; only the two low address bits matter for alignment.
  function automatic logic [1:0] flags_f(input logic chk, input logic bad,
                                         input logic [1:0] size, input logic [1:0] lsb);
    logic [1:0] f;
    f = {bad, 1'b0};
    if (chk) begin
      case (size)
        2'b01:   f[0] = lsb[0];
        2'b10:   f[0] = |lsb;
        2'b11:   f[1] = 1'b1;
        default: ;
      endcase
    end
    return f;
  endfunction

  // ---- stage p0: decode the incoming request ----
  assign sext_p0 = {{(ADDR_W-IMM_W){bus.i_offset[IMM_W-1]}}, bus.i_offset[IMM_W-1:0]};
  assign chk_p0  = (bus.i_opcode == OP_REG) || (bus.i_opcode == OP_BOFF) ||
                   (bus.i_opcode == OP_BURST);
  assign bad_p0  = (bus.i_opcode > OP_BURST);
  assign last_p0 = (bus.i_opcode != OP_BURST) || (bus.i_beats == '0);

  always_comb begin
    addr_p0 = bus.i_addr;
    case (bus.i_opcode)
      OP_BOFF, OP_BURST: addr_p0 = bus.i_addr + sext_p0;
      OP_BRANCH:         addr_p0 = bus.i_addr + (sext_p0 <<< 2);
      OP_JUMP:           addr_p0 = {bus.i_addr[ADDR_W-1:OFF_W+2], bus.i_offset, 2'b00};
      default:           ;
    endcase
  end

  assign exc_p0 = flags_f(chk_p0, bad_p0, bus.i_size, addr_p0[1:0]);

  // ---- handshake FSM ----
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (load) state_d = S_OUT;
      S_OUT:  if (bus.i_ready && last_p1 && !load) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    vld_p1 = (state_q == S_OUT);
    rdy    = !vld_p1 || (bus.i_ready && last_p1);
    load   = bus.i_valid && rdy;
    step   = vld_p1 && bus.i_ready && !last_p1;
  end

  // ---- stage p1: registered result / burst walker ----
  assign stride_p1    = ADDR_W'(1) << size_p1;
  assign next_addr_p1 = eff_addr_p1 + stride_p1;
  assign next_beat_p1 = beat_p1 + BEAT_W'(1);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      eff_addr_p1 <= '0;
      exc_p1      <= '0;
      beat_p1     <= '0;
      last_p1     <= 1'b0;
      lim_p1      <= '0;
      size_p1     <= '0;
    end else if (load) begin
      eff_addr_p1 <= addr_p0;
      exc_p1      <= exc_p0;
      beat_p1     <= '0;
      last_p1     <= last_p0;
      lim_p1      <= bus.i_beats;
      size_p1     <= bus.i_size;
    end else if (step) begin
      // Later burst beats re-derive flags from the stepped address; wrap is silent.
      eff_addr_p1 <= next_addr_p1;
      exc_p1      <= flags_f(1'b1, 1'b0, size_p1, next_addr_p1[1:0]);
      beat_p1     <= next_beat_p1;
      last_p1     <= (next_beat_p1 == lim_p1);
    end
  end

  assign bus.o_valid          = vld_p1;
  assign bus.o_ready          = rdy;
  assign bus.o_eff_addr       = eff_addr_p1;
  assign bus.o_addr_exception = exc_p1;
  assign bus.o_beat_idx       = beat_p1;
  assign bus.o_last           = last_p1;

endmodule

// File: tb/tb_agu_pipe.sv
// Bench for agu_pipe: directed vector table, multi-cycle corner sequences and a
// randomized run scored against a beat-list reference model.
module tb_agu_pipe;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  agu_if bus ();

  agu_pipe dut (
    .i_clk  (clk),
    .i_rst_n(rst_n),
    .bus    (bus)
  );

  typedef struct packed {
    logic [31:0] a;
    logic [1:0]  e;
    logic [2:0]  idx;
    logic        last;
  } beat_t;

  beat_t q[$];

  typedef struct {
    logic [2:0]  op;
    logic [31:0] addr;
    logic [25:0] off;
    logic [1:0]  size;
    logic [31:0] exp_addr;
    logic [1:0]  exp_exc;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Expected beat list of one accepted request, from the addressing rules directly.
  function automatic void model_push(input logic [2:0] op, input logic [31:0] base,
                                     input logic [25:0] off, input logic [1:0] sz,
                                     input logic [2:0] nb);
    int    imm;
    int    n;
    logic  mem_mode;
    logic  ill, mis;
    logic [31:0] a;
    beat_t b;
    imm      = int'($signed(off[15:0]));
    n        = (op == 3'd4) ? int'(nb) + 1 : 1;
    mem_mode = (op == 3'd0) || (op == 3'd1) || (op == 3'd4);
    for (int k = 0; k < n; k++) begin
      case (op)
        3'd0:       a = base;
        3'd1, 3'd4: a = base + 32'(imm) + 32'(k * (1 << sz));
        3'd2:       a = base + 32'(imm * 4);
        3'd3:       a = {base[31:28], off, 2'b00};
        default:    a = base;
      endcase
      ill = (op > 3'd4) || (mem_mode && sz == 2'd3);
      mis = mem_mode && ((sz == 2'd1 && (a % 32'd2) != 0) || (sz == 2'd2 && (a % 32'd4) != 0));
      b.a    = a;
      b.e    = {ill, mis};
      b.idx  = (op == 3'd4) ? 3'(k) : 3'd0;
      b.last = (k == n - 1);
      q.push_back(b);
    end
  endfunction

  // Scoreboard: the output must always present the head of the expected beat list.
  always @(negedge clk) begin
    if (!rst_n) begin
      q.delete();
    end else begin
      chk("mon_valid", 32'(bus.o_valid), 32'(q.size() != 0));
      chk("mon_ready", 32'(bus.o_ready), 32'((q.size() == 0) || (bus.i_ready && q.size() == 1)));
      if (q.size() != 0 && bus.o_valid) begin
        chk("mon_addr", bus.o_eff_addr, q[0].a);
        chk("mon_exc",  32'(bus.o_addr_exception), 32'(q[0].e));
        chk("mon_idx",  32'(bus.o_beat_idx), 32'(q[0].idx));
        chk("mon_last", 32'(bus.o_last), 32'(q[0].last));
        if (bus.i_ready) void'(q.pop_front());
      end
      if (bus.i_valid && bus.o_ready)
        model_push(bus.i_opcode, bus.i_addr, bus.i_offset, bus.i_size, bus.i_beats);
    end
  end

  task automatic drive(input logic [2:0] op, input logic [31:0] a, input logic [25:0] off,
                       input logic [1:0] sz, input logic [2:0] nb);
    bus.i_opcode = op;
    bus.i_addr   = a;
    bus.i_offset = off;
    bus.i_size   = sz;
    bus.i_beats  = nb;
  endtask

  vec_t vt[10];
  int   rp[6];
  int   ix[6];
  int   drain;

  initial begin
    bus.i_valid = 1'b0;
    bus.i_ready = 1'b1;
    drive(3'd0, 32'd0, 26'd0, 2'd0, 3'd0);

    vt[0] = '{3'b001, 32'h0000_1000, 26'h000_FFFC, 2'd2, 32'h0000_0FFC, 2'b00};
    vt[1] = '{3'b001, 32'h0000_1001, 26'h000_0000, 2'd1, 32'h0000_1001, 2'b01};
    vt[2] = '{3'b001, 32'h0000_1001, 26'h000_0000, 2'd0, 32'h0000_1001, 2'b00};
    vt[3] = '{3'b110, 32'h0000_1234, 26'h000_0000, 2'd0, 32'h0000_1234, 2'b10};
    vt[4] = '{3'b010, 32'h0040_0004, 26'h000_FFFF, 2'd2, 32'h0040_0000, 2'b00};
    vt[5] = '{3'b011, 32'hA000_0000, 26'h000_0010, 2'd2, 32'hA000_0040, 2'b00};
    vt[6] = '{3'b000, 32'h1234_5677, 26'h000_0000, 2'd2, 32'h1234_5677, 2'b01};
    vt[7] = '{3'b001, 32'h0000_0100, 26'h000_0000, 2'd3, 32'h0000_0100, 2'b10};
    vt[8] = '{3'b010, 32'h0000_0003, 26'h000_0000, 2'd2, 32'h0000_0003, 2'b00};
    vt[9] = '{3'b101, 32'h0000_0007, 26'h000_0000, 2'd2, 32'h0000_0007, 2'b10};

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", 32'(bus.o_valid), 32'd0);
    chk("rst_addr",  bus.o_eff_addr, 32'd0);
    chk("rst_exc",   32'(bus.o_addr_exception), 32'd0);
    chk("rst_idx",   32'(bus.o_beat_idx), 32'd0);
    chk("rst_last",  32'(bus.o_last), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rst_ready", 32'(bus.o_ready), 32'd1);

    // Single-result vector table
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      drive(vt[i].op, vt[i].addr, vt[i].off, vt[i].size, 3'd0);
      bus.i_valid = 1'b1;
      @(posedge clk); #1;
      bus.i_valid = 1'b0;
      @(negedge clk);
      chk($sformatf("vec%0d_valid", i), 32'(bus.o_valid), 32'd1);
      chk($sformatf("vec%0d_addr", i),  bus.o_eff_addr, vt[i].exp_addr);
      chk($sformatf("vec%0d_exc", i),   32'(bus.o_addr_exception), 32'(vt[i].exp_exc));
      chk($sformatf("vec%0d_last", i),  32'(bus.o_last), 32'd1);
      chk($sformatf("vec%0d_idx", i),   32'(bus.o_beat_idx), 32'd0);
    end

    // Backpressure hold on a single result
    @(posedge clk); #1;
    drive(3'b001, 32'h0000_1000, 26'h000_FFFC, 2'd2, 3'd0);
    bus.i_valid = 1'b1;
    @(posedge clk); #1;
    bus.i_valid = 1'b0;
    bus.i_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("hold_valid", 32'(bus.o_valid), 32'd1);
      chk("hold_addr",  bus.o_eff_addr, 32'h0000_0FFC);
      chk("hold_exc",   32'(bus.o_addr_exception), 32'd0);
      chk("hold_last",  32'(bus.o_last), 32'd1);
      chk("hold_ready", 32'(bus.o_ready), 32'd0);
    end
    @(posedge clk); #1;
    bus.i_ready = 1'b1;
    @(negedge clk);
    chk("hold_release_ready", 32'(bus.o_ready), 32'd1);
    @(negedge clk);
    chk("hold_drained", 32'(bus.o_valid), 32'd0);

    // Burst with a 2-cycle stall on beat 1, next request waiting behind it
    rp = '{1, 0, 0, 1, 1, 1};
    ix = '{0, 1, 1, 1, 2, 3};
    @(posedge clk); #1;
    drive(3'b100, 32'h0000_2000, 26'h000_0004, 2'd2, 3'd3);
    bus.i_valid = 1'b1;
    @(posedge clk); #1;
    drive(3'b000, 32'h0000_0054, 26'h0, 2'd2, 3'd0);
    for (int c = 0; c < 6; c++) begin
      if (c > 0) begin
        @(posedge clk); #1;
      end
      bus.i_ready = rp[c][0];
      @(negedge clk);
      chk($sformatf("burst_c%0d_addr", c),  bus.o_eff_addr, 32'h0000_2004 + 32'(4 * ix[c]));
      chk($sformatf("burst_c%0d_idx", c),   32'(bus.o_beat_idx), 32'(ix[c]));
      chk($sformatf("burst_c%0d_last", c),  32'(bus.o_last), 32'(ix[c] == 3));
      chk($sformatf("burst_c%0d_ready", c), 32'(bus.o_ready), 32'(ix[c] == 3 && rp[c] == 1));
    end
    @(posedge clk); #1;
    bus.i_valid = 1'b0;
    @(negedge clk);
    chk("burst_next_addr", bus.o_eff_addr, 32'h0000_0054);
    chk("burst_next_last", 32'(bus.o_last), 32'd1);
    chk("burst_next_idx",  32'(bus.o_beat_idx), 32'd0);

    // Burst address wrap
    @(posedge clk); #1;
    drive(3'b100, 32'hFFFF_FFFC, 26'h0, 2'd2, 3'd1);
    bus.i_valid = 1'b1;
    @(posedge clk); #1;
    bus.i_valid = 1'b0;
    @(negedge clk);
    chk("wrap_b0_addr", bus.o_eff_addr, 32'hFFFF_FFFC);
    chk("wrap_b0_last", 32'(bus.o_last), 32'd0);
    @(negedge clk);
    chk("wrap_b1_addr", bus.o_eff_addr, 32'h0000_0000);
    chk("wrap_b1_last", 32'(bus.o_last), 32'd1);
    chk("wrap_b1_exc",  32'(bus.o_addr_exception), 32'd0);

    // Ten back-to-back register-mode requests
    for (int i = 0; i <= 10; i++) begin
      @(posedge clk); #1;
      if (i < 10) begin
        drive(3'b000, 32'(i * 16), 26'h0, 2'd2, 3'd0);
        bus.i_valid = 1'b1;
      end else begin
        bus.i_valid = 1'b0;
      end
      @(negedge clk);
      if (i > 0) begin
        chk($sformatf("b2b%0d_valid", i), 32'(bus.o_valid), 32'd1);
        chk($sformatf("b2b%0d_addr", i),  bus.o_eff_addr, 32'((i - 1) * 16));
      end
      if (i < 10) chk($sformatf("b2b%0d_ready", i), 32'(bus.o_ready), 32'd1);
    end

    // Asynchronous reset in the middle of a burst
    @(posedge clk); #1;
    drive(3'b100, 32'h0000_0100, 26'h0, 2'd0, 3'd7);
    bus.i_valid = 1'b1;
    @(posedge clk); #1;
    bus.i_valid = 1'b0;
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    chk("arst_valid", 32'(bus.o_valid), 32'd0);
    chk("arst_addr",  bus.o_eff_addr, 32'd0);
    chk("arst_idx",   32'(bus.o_beat_idx), 32'd0);
    chk("arst_last",  32'(bus.o_last), 32'd0);
    chk("arst_ready", 32'(bus.o_ready), 32'd1);
    @(negedge clk);
    @(negedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("arst_after_valid", 32'(bus.o_valid), 32'd0);

    // Randomized traffic with random backpressure
    for (int i = 0; i < 600; i++) begin
      @(posedge clk); #1;
      drive(3'($urandom_range(0, 7)),
            ($urandom_range(0, 1) != 0) ? ($urandom & 32'hFFFF_FFFC) : $urandom,
            26'($urandom), 2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)));
      bus.i_valid = ($urandom_range(0, 2) != 0);
      bus.i_ready = ($urandom_range(0, 3) != 0);
    end
    @(posedge clk); #1;
    bus.i_valid = 1'b0;
    bus.i_ready = 1'b1;
    drain = 0;
    while (q.size() != 0 && drain < 20) begin
      @(posedge clk); #1;
      drain++;
    end
    chk("drain_empty", 32'(q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/agu_pipe.md
Name: agu_pipe

Overview:
- Registered, handshaked address generation unit for the MIPS datapath. Sits between the ID/EX operand latch and the memory/PC-update stage.
- Computes the effective address for register, base+offset, branch, jump and multi-beat burst modes.
- Checks alignment against the access size. Under backpressure it holds results stable with a valid/ready handshake.

Parameters:
- ADDR_W, 32, address/data width; must be ≥ OFF_W+3.
- IMM_W, 16, signed immediate field width (low bits of i_offset).
- OFF_W, 26, jump field width.
- MAX_BEATS, 8, maximum burst length; must be ≥ 2.
- BEAT_W, $clog2(MAX_BEATS), width of beat count/index.

Ports:
- i_clk  in  1  clock; one clock domain.
- i_rst_n  in  1  reset; asynchronous, active-low.
- i_valid  in  1  request valid.
- o_ready  out  1  request accepted when i_valid && o_ready.
- i_opcode  in  3  mode select.
- i_addr  in  ADDR_W  base (RS value or PC+4).
- i_offset  in  OFF_W  immediate/jump field.
- i_size  in  2  access size: 00 byte, 01 half, 10 word, 11 reserved.
- i_beats  in  BEAT_W  burst length minus 1.
- o_valid  out  1  result valid.
- i_ready  in  1  consumer ready.
- o_eff_addr  out  ADDR_W  effective address.
- o_addr_exception  out  2  {illegal, misaligned}.
- o_beat_idx  out  BEAT_W  current beat number.
- o_last  out  1  final beat of the request.

Behaviour:
- Reset (async, i_rst_n=0): state IDLE; o_valid=0, o_eff_addr=0, o_addr_exception=0, o_beat_idx=0, o_last=0. Takes effect mid-burst too; a pending burst is discarded. First request is acceptable on the first rising edge after i_rst_n rises.
- o_ready = !o_valid || (i_ready && o_last). Combinational, with no dependency on i_valid.
- Latency: 1 cycle from accept to o_valid. Back-to-back single requests sustain 1 per cycle.
- Output hold: while o_valid && !i_ready, all outputs are held bit-stable.
- Immediate sign extension: sext = sign-extend i_offset[IMM_W-1:0] to ADDR_W. All adds are modulo 2^ADDR_W; there is no overflow flag.
- Opcode 000 (register): addr = i_addr.
- Opcode 001 (base+offset): addr = i_addr + sext.
- Opcode 010 (branch): addr = i_addr + (sext << 2).
- Opcode 011 (jump): addr = {i_addr[ADDR_W-1:OFF_W+2], i_offset, 2'b00}.
- Opcode 100 (burst):
  - beat k address = i_addr + sext + k*(1<<i_size), for k = 0..i_beats.
  - Operands are latched at accept. i_beats=0 gives a single beat.
- Opcodes 101–111: addr = i_addr; illegal=1.
- Misaligned flag:
  - Modes 000/001/100 only: i_size=01 && addr[0]; i_size=10 && addr[1:0]!=0; i_size=11 sets illegal=1.
  - Modes 010/011: misaligned=0.
- Flags are recomputed on every beat and every accept; no flag is sticky.
- o_last = 1 for all non-burst results, and on beat k == latched i_beats for bursts. o_beat_idx = 0 for non-burst results.
- FSM:
  - IDLE --accept--> OUT.
  - OUT --i_ready && o_last && !accept--> IDLE.
  - OUT --i_ready && o_last && accept--> OUT, loading new result.
  - OUT --i_ready && !o_last--> OUT: advance beat, add stride, update flags and o_last.
  - OUT --!i_ready--> hold.
- Exceptions do not abort a burst; all beats are issued and the consumer decides.
- Address wrap past 2^ADDR_W-1 during a burst wraps to 0 silently.

Test Plan:
- Reset/idle: hold i_rst_n=0, then release -> all outputs 0, o_ready=1. Assert i_rst_n=0 mid-burst -> o_valid=0 immediately (asynchronous).
- Base+offset, backpressure: op=001, i_addr=0x1000, offset=0xFFFC, size=10 -> next cycle o_eff_addr=0x0FFC, exc=00, o_last=1. With i_ready=0 for 3 cycles, outputs are held and o_ready=0.
- Misaligned and illegal:
  - op=001, i_addr=0x1001, offset=0, size=01 -> exc=01.
  - Same request with size=00 -> exc=00.
  - op=110 -> exc=10.
- Branch/jump:
  - op=010, i_addr=0x00400004, offset=0xFFFF -> 0x00400000.
  - op=011, i_addr=0xA0000000, offset=0x0000010 -> 0xA0000040.
- Burst with stall: op=100, i_addr=0x2000, offset=4, size=10, i_beats=3 -> addresses 0x2004, 0x2008, 0x200C, 0x2010; o_beat_idx 0..3; o_last only on beat 3. With i_ready low on beat 1 for 2 cycles, beat 1 is held. o_ready=0 until the accept cycle of beat 3.
- Wrap and throughput:
  - Burst from 0xFFFFFFFC, size=10, i_beats=1 -> 0xFFFFFFFC, then 0x00000000.
  - Ten back-to-back op=000 requests with i_ready=1 -> ten results on ten consecutive cycles.
